// File: rtl/wall_map.sv
// Level wall map: 64x44 one-bit store filled with the level pattern on load,
// with an optional clear FIFO for destructible walls (macro WALL_DESTRUCT_EN).
//
// state  | meaning
// S_LOAD | writing level pattern, one cell per cycle; outputs gated
// S_RUN  | map live for display reads, queries and (optionally) clears
module wall_map (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_buzy,
    input  logic [5:0] i_request_x,
    input  logic [5:0] i_request_y,
    output logic       o_is_wall,
    input  logic [5:0] i_query_x,
    input  logic [5:0] i_query_y,
    output logic       o_query_wall,
    input  logic       i_load,
    output logic       o_loading,
    input  logic       i_clear_valid,
    input  logic [5:0] i_clear_x,
    input  logic [5:0] i_clear_y,
    output logic       o_clear_ready
);

    typedef enum logic {S_LOAD, S_RUN} state_t;

    localparam logic [11:0] LAST_CELL = 12'd2815;
    localparam logic [5:0]  ROWS      = 6'd44;

    state_t        state_q, state_d;
    logic [11:0]   load_cnt_q, load_cnt_d;
    logic [2815:0] map_q;
    logic          is_wall_q;
    logic          map_we;
    logic [11:0]   map_waddr;
    logic          map_wdata;

    function automatic logic level_wall(input logic [5:0] x, input logic [5:0] y);
        return (x == 6'd0) || (x == 6'd63) || (y == 6'd0) || (y == 6'd43) ||
               ((x[2:0] == 3'd4) && (y[2:0] == 3'd4));
    endfunction

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        if (i_load) begin
            state_d    = S_LOAD;
            load_cnt_d = '0;
        end else if (state_q == S_LOAD) begin
            if (load_cnt_q == LAST_CELL) state_d = S_RUN;
            else                         load_cnt_d = load_cnt_q + 12'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_LOAD;
            load_cnt_q <= '0;
            is_wall_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            // map_q is read before this edge's write lands: a same-cycle clear shows next read
            is_wall_q  <= (state_q == S_RUN && i_request_y < ROWS) ?
                          map_q[{i_request_y, i_request_x}] : 1'b0;
        end
    end

`ifdef WALL_DESTRUCT_EN
    logic [11:0] fifo_mem_q [4];
    logic [1:0]  wr_ptr_q, rd_ptr_q;
    logic [2:0]  count_q;
    logic        push, pop, clear_we;
    logic [11:0] fifo_head;

    assign o_clear_ready = (state_q == S_RUN) && (count_q != 3'd4);
    assign push          = i_clear_valid && o_clear_ready && !i_load;
    assign pop           = (state_q == S_RUN) && !i_buzy && (count_q != 3'd0);
    assign fifo_head     = fifo_mem_q[rd_ptr_q];
    assign clear_we      = pop && (fifo_head[11:6] < ROWS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (i_load) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
            count_q <= count_q + {2'b0, push} - {2'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= {i_clear_y, i_clear_x};
    end
`else
    logic unused_clear;
    assign unused_clear  = ^{i_buzy, i_clear_valid, i_clear_x, i_clear_y};
    assign o_clear_ready = 1'b0;
`endif

    always_comb begin
        map_we    = 1'b0;
        map_waddr = load_cnt_q;
        map_wdata = 1'b0;
        if (state_q == S_LOAD) begin
            map_we    = 1'b1;
            map_wdata = level_wall(load_cnt_q[5:0], load_cnt_q[11:6]);
        end
`ifdef WALL_DESTRUCT_EN
        else if (clear_we) begin
            map_we    = 1'b1;
            map_waddr = fifo_head;
        end
`endif
    end

    // No reset on the array: contents are only meaningful after a full load.
    always_ff @(posedge clk) begin
        if (map_we) map_q[map_waddr] <= map_wdata;
    end

    assign o_is_wall    = is_wall_q;
    assign o_loading    = (state_q == S_LOAD);
    assign o_query_wall = (state_q == S_LOAD || i_query_y >= ROWS) ? 1'b1 :
                          map_q[{i_query_y, i_query_x}];

endmodule

// File: tb/tb_wall_map.sv
// Self-checking bench for wall_map: random display/query/clear traffic against a
// cell-array + queue model, plus directed load, reload and FIFO scenarios.
module tb_wall_map;

    logic       clk = 1'b0;
    logic       rst_n, i_buzy, i_load, i_clear_valid;
    logic [5:0] i_request_x, i_request_y, i_query_x, i_query_y, i_clear_x, i_clear_y;
    logic       o_is_wall, o_query_wall, o_loading, o_clear_ready;

    int ntests = 0;
    int nfail  = 0;

    bit          mdl_map [0:2815];
    bit          model_run;
    logic [11:0] fifo_q [$];

    always #5 clk = ~clk;

    wall_map dut (
        .clk(clk), .rst_n(rst_n), .i_buzy(i_buzy),
        .i_request_x(i_request_x), .i_request_y(i_request_y), .o_is_wall(o_is_wall),
        .i_query_x(i_query_x), .i_query_y(i_query_y), .o_query_wall(o_query_wall),
        .i_load(i_load), .o_loading(o_loading),
        .i_clear_valid(i_clear_valid), .i_clear_x(i_clear_x), .i_clear_y(i_clear_y),
        .o_clear_ready(o_clear_ready)
    );

    function automatic bit pattern(int x, int y);
        return x == 0 || x == 63 || y == 0 || y == 43 || (x % 8 == 4 && y % 8 == 4);
    endfunction

    function automatic bit mdl_query(int x, int y);
        if (!model_run || y >= 44) return 1'b1;
        return mdl_map[y * 64 + x];
    endfunction

    task automatic check_eq(string tag, int act, int exp);
        ntests++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic model_reload();
        for (int y = 0; y < 44; y++)
            for (int x = 0; x < 64; x++)
                mdl_map[y * 64 + x] = pattern(x, y);
        fifo_q.delete();
        model_run = 1'b1;
    endtask

    // Inputs are set by the caller just after an edge; this checks the
    // combinational outputs, advances one clock and checks the registered read.
    task automatic tick();
        bit exp_wall, ready_pre;
        logic [11:0] e;
        #1;
        exp_wall = (!model_run || i_request_y >= 44) ? 1'b0 : mdl_map[i_request_y * 64 + i_request_x];
        ready_pre = 1'b0;
`ifdef WALL_DESTRUCT_EN
        ready_pre = model_run && fifo_q.size() < 4;
`endif
        check_eq("clear_ready", o_clear_ready, ready_pre);
        check_eq("query_wall", o_query_wall, mdl_query(i_query_x, i_query_y));
`ifdef WALL_DESTRUCT_EN
        if (model_run && !i_buzy && fifo_q.size() > 0) begin
            e = fifo_q.pop_front();
            if (e[11:6] < 44) mdl_map[e[11:6] * 64 + e[5:0]] = 1'b0;
        end
        if (i_clear_valid && ready_pre) fifo_q.push_back({i_clear_y, i_clear_x});
`endif
        @(posedge clk);
        #1;
        check_eq("is_wall", o_is_wall, exp_wall);
    endtask

    task automatic pulse_load();
        i_load        = 1'b1;
        i_clear_valid = 1'b0;
        @(posedge clk);
        #1;
        i_load    = 1'b0;
        model_run = 1'b0;
        fifo_q.delete();
    endtask

    task automatic wait_load();
        int cyc;
        cyc = 0;
        i_request_x = 6'd4; i_request_y = 6'd4;
        i_query_x   = 6'd5; i_query_y   = 6'd5;
        while (o_loading && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 100) begin
                check_eq("load_is_wall", o_is_wall, 0);
                check_eq("load_query", o_query_wall, 1);
            end
        end
        check_eq("load_len", cyc, 2816);
        model_reload();
    endtask

    task automatic push_cell(int x, int y);
        i_clear_valid = 1'b1;
        i_clear_x = 6'(x); i_clear_y = 6'(y);
        tick();
        i_clear_valid = 1'b0;
    endtask

    task automatic sweep_map();
        for (int y = 0; y < 44; y++)
            for (int x = 0; x < 64; x++) begin
                i_query_x = 6'(x); i_query_y = 6'(y);
                #1;
                if (o_query_wall !== pattern(x, y))
                    check_eq($sformatf("sweep_%0d_%0d", x, y), o_query_wall, pattern(x, y));
                else
                    ntests++;
            end
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_run = 1'b0;
        rst_n = 1'b0; i_buzy = 1'b1; i_load = 1'b0; i_clear_valid = 1'b0;
        i_request_x = '0; i_request_y = '0; i_query_x = '0; i_query_y = '0;
        i_clear_x = '0; i_clear_y = '0;
        #3;
        check_eq("rst_loading", o_loading, 1);
        check_eq("rst_ready", o_clear_ready, 0);
        check_eq("rst_is_wall", o_is_wall, 0);
        check_eq("rst_query", o_query_wall, 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_load();

        i_query_x = 6'd0;  i_query_y = 6'd5;  #1; check_eq("q_0_5", o_query_wall, 1);
        i_query_x = 6'd4;  i_query_y = 6'd4;  #1; check_eq("q_4_4", o_query_wall, 1);
        i_query_x = 6'd5;  i_query_y = 6'd5;  #1; check_eq("q_5_5", o_query_wall, 0);
        i_query_x = 6'd12; i_query_y = 6'd20; #1; check_eq("q_12_20", o_query_wall, 1);
        i_query_x = 6'd63; i_query_y = 6'd43; #1; check_eq("q_63_43", o_query_wall, 1);
        i_query_x = 6'd5;  i_query_y = 6'd50; #1; check_eq("q_oob", o_query_wall, 1);
        @(posedge clk); #1;

        i_request_x = 6'd4; i_request_y = 6'd4;  tick(); check_eq("req_4_4", o_is_wall, 1);
        i_request_x = 6'd3; i_request_y = 6'd50; tick(); check_eq("req_3_50", o_is_wall, 0);
        i_request_x = 6'd5; i_request_y = 6'd5;  tick(); check_eq("req_5_5", o_is_wall, 0);

`ifdef WALL_DESTRUCT_EN
        i_buzy = 1'b1;
        for (int k = 0; k < 5; k++) push_cell(4 + 8 * k, 4);
        check_eq("full_ready", o_clear_ready, 0);
        i_buzy = 1'b0;
        tick(); tick();
        i_buzy = 1'b1;
        i_query_x = 6'd12; i_query_y = 6'd4;
        tick();
        check_eq("after_drain_ready", o_clear_ready, 1);
        check_eq("cleared_12_4", o_query_wall, 0);
        i_buzy = 1'b0;
        repeat (4) tick();

        i_buzy = 1'b1;
        push_cell(4, 12);
        i_buzy = 1'b0;
        i_request_x = 6'd4; i_request_y = 6'd12;
        push_cell(12, 12);
        check_eq("same_cycle_is_wall_pre", o_is_wall, 1);
        i_query_x = 6'd4; i_query_y = 6'd12;
        i_buzy = 1'b1;
        tick();
        check_eq("same_cycle_cleared", o_query_wall, 0);
        check_eq("is_wall_post", o_is_wall, 0);
        i_buzy = 1'b0;
        repeat (2) tick();
`else
        i_buzy = 1'b0;
        i_query_x = 6'd4; i_query_y = 6'd4;
        i_request_x = 6'd4; i_request_y = 6'd4;
        for (int k = 0; k < 4; k++) push_cell(4, 4);
        check_eq("nodes_ready", o_clear_ready, 0);
        check_eq("nodes_keep", o_query_wall, 1);
        check_eq("nodes_is_wall", o_is_wall, 1);
`endif

        for (int n = 0; n < 400; n++) begin
            i_buzy        = ($urandom_range(0, 2) != 0);
            i_clear_valid = $urandom_range(0, 1);
            i_clear_x     = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 7) * 8 + 4) : 6'($urandom_range(0, 63));
            i_clear_y     = 6'($urandom_range(0, 47));
            i_request_x   = 6'($urandom_range(0, 63));
            i_request_y   = 6'($urandom_range(0, 47));
            i_query_x     = ($urandom_range(0, 1) != 0) ? i_clear_x : 6'($urandom_range(0, 63));
            i_query_y     = ($urandom_range(0, 1) != 0) ? i_clear_y : 6'($urandom_range(0, 47));
            tick();
        end
        i_clear_valid = 1'b0;

        i_buzy = 1'b1;
        push_cell(0, 10);
        push_cell(4, 20);
        push_cell(63, 30);
        pulse_load();
        check_eq("reload_loading", o_loading, 1);
        repeat (999) @(posedge clk);
        #1;
        pulse_load();
        i_buzy = 1'b0;
        wait_load();
        sweep_map();
        i_query_x = 6'd0; i_query_y = 6'd10;
        repeat (4) tick();
        check_eq("restored_0_10", o_query_wall, 1);
        i_query_x = 6'd63; i_query_y = 6'd30;
        #1;
        check_eq("restored_63_30", o_query_wall, 1);

        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("async_loading", o_loading, 1);
        check_eq("async_is_wall", o_is_wall, 0);
        check_eq("async_ready", o_clear_ready, 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/wall_map.md
WALL_MAP -- requirements
Module: wall_map

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have port i_buzy  input  1  display busy flag; low only in the frame-end window.
REQ-004 SHALL have port i_request_x  input  6  display cell column, 0..63.
REQ-005 SHALL have port i_request_y  input  6  display game-row, 0..43.
REQ-006 SHALL have port o_is_wall  output  1  wall bit for the requested cell.
REQ-007 SHALL have port i_query_x / i_query_y  input  6 each  game-logic collision query cell.
REQ-008 SHALL have port o_query_wall  output  1  wall bit for the query cell, combinational.
REQ-009 SHALL have port i_load  input  1  one-cycle pulse that restarts the level load.
REQ-010 SHALL have port o_loading  output  1  high while the LOAD state is active.
REQ-011 SHALL have port i_clear_valid  input  1  request to remove a wall.
REQ-012 SHALL have port i_clear_x / i_clear_y  input  6 each  cell to clear.
REQ-013 SHALL have port o_clear_ready  output  1  clear request accepted this cycle when high with valid.

Function
REQ-014 SHALL store a 64x44 one-bit map; cell index = y*64 + x.
REQ-015 SHALL implement the FSM LOAD -> RUN; LOAD is entered on reset release or on i_load in any state.
REQ-016 In LOAD, SHALL write one cell per cycle, incrementing x 0..63 and wrapping to y+1, for 2816 cycles total; RUN SHALL be entered the cycle after cell (63,43) is written.
REQ-017 Level pattern: a cell SHALL be a wall iff x==0, x==63, y==0, y==43, or (x[2:0]==4 and y[2:0]==4).
REQ-018 o_is_wall SHALL be registered with 1-cycle latency from i_request_x/y.
REQ-019 o_is_wall SHALL be 0 while in LOAD and for any request with y>=44.
REQ-020 o_query_wall SHALL reflect the current map contents combinationally, SHALL be 1 for y>=44, and SHALL be 1 during LOAD.
REQ-021 Clear requests SHALL be buffered in a 4-entry FIFO; o_clear_ready SHALL equal (state==RUN && FIFO not full).
REQ-022 When state==RUN, i_buzy==0, and the FIFO is not empty, exactly one entry SHALL be popped per cycle and its cell set to 0; entries with y>=44 SHALL be popped and discarded.
REQ-023 A push and a pop in the same cycle SHALL both take effect, leaving the count unchanged.
REQ-024 A clear of a cell that is already 0 SHALL leave it 0.
REQ-025 A pop that targets the currently requested display cell SHALL make o_is_wall show the pre-clear value in that cycle and the new value on the next read.
REQ-026 i_load SHALL flush the FIFO, discard all pending clears, and restart the load at (0,0), including when a load is already in progress.

Reset
REQ-027 On rst_n low, the module SHALL immediately set: state=LOAD, load counter=0, FIFO empty, o_is_wall=0, o_clear_ready=0, o_loading=1.
REQ-028 Map contents are undefined during reset and SHALL be valid only after LOAD completes.

Configuration
REQ-029 The macro WALL_DESTRUCT_EN SHALL control the destructible-wall feature.
REQ-030 With WALL_DESTRUCT_EN defined, the FIFO and clear path SHALL be present as specified.
REQ-031 Without WALL_DESTRUCT_EN, there SHALL be no FIFO, o_clear_ready SHALL be tied to 0, i_clear_* SHALL be ignored, and the map SHALL change only in LOAD.

Verification
REQ-032 Reset release, wait 2816 cycles -> o_loading falls; query (0,5)=1, (4,4)=1, (5,5)=0, (12,20)=1, (63,43)=1.
REQ-033 In RUN, request (4,4) at cycle n -> o_is_wall=1 at n+1; request (3,50) -> o_is_wall=0.
REQ-034 With i_buzy=1, push 5 clears back-to-back -> 4 accepted and o_clear_ready=0 on the 5th; drop i_buzy for 2 cycles -> 2 cells cleared and o_clear_ready=1.
REQ-035 FIFO holds 1 entry, i_buzy=0, push on the same cycle -> count remains 1 and the first cell reads 0 next cycle.
REQ-036 Pulse i_load mid-load at count 1000 and with 3 clears pending -> FIFO empty, load restarts, RUN reached 2816 cycles later, and the cleared walls are restored.
REQ-037 Build without WALL_DESTRUCT_EN, drive i_clear_valid=1 for (4,4) -> o_clear_ready=0 and (4,4) stays 1.
